// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered MIPS ID stage with ID/EX register, load-use and HI/LO hazard stalls.
// Bubbles, flush and downstream hold are resolved on each edge: hold > flush > stall > accept.
module decode_stage_pipe #(
    parameter int ALUOP_W     = 6,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [31:0]        id_instr,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_jumplink,
    output logic               ex_jr,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [1:0]         ex_load,
    output logic [1:0]         ex_store,
    output logic [4:0]         ex_dest,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic               ex_illegal
);
    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic               branch;
        logic               jump;
        logic               jumplink;
        logic               jr;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         load;
        logic [1:0]         store;
        logic [4:0]         dest;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic               illegal;
    } ctrl_t;

    localparam ctrl_t BUBBLE = ctrl_t'({10'b0, {ALUOP_W{1'b0}}, 4'b1111, 16'b0});

    localparam logic [ALUOP_W-1:0] A_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] A_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] A_AND   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] A_OR    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] A_XOR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] A_NOR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] A_SLT   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] A_SLTU  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] A_SLL   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] A_SRL   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] A_SRA   = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] A_SLLV  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] A_SRLV  = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] A_SRAV  = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] A_LUI   = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] A_ADDU  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] A_SUBU  = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] A_MULT  = ALUOP_W'(17);
    localparam logic [ALUOP_W-1:0] A_MULTU = ALUOP_W'(18);
    localparam logic [ALUOP_W-1:0] A_MFHI  = ALUOP_W'(19);
    localparam logic [ALUOP_W-1:0] A_MFLO  = ALUOP_W'(20);
    localparam logic [ALUOP_W-1:0] A_MTHI  = ALUOP_W'(21);
    localparam logic [ALUOP_W-1:0] A_MTLO  = ALUOP_W'(22);
    localparam logic [ALUOP_W-1:0] A_MADD  = ALUOP_W'(23);
    localparam logic [ALUOP_W-1:0] A_MSUB  = ALUOP_W'(24);
    localparam logic [ALUOP_W-1:0] A_MUL   = ALUOP_W'(25);

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_JAL      = 6'h03;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;
    ctrl_t      dec, ex_q, ex_d;
    logic [CNT_W-1:0] busy_q, busy_d;
    logic       uses_rt, hilo_op, mul_op, r_alu, i_alu;
    logic       load_use, hilo_use, stall, accept;

    assign op           = id_instr[31:26];
    assign fn           = id_instr[5:0];
    assign rs           = id_instr[25:21];
    assign rt           = id_instr[20:16];
    assign rd           = id_instr[15:11];
    assign unused_shamt = ^id_instr[10:6];

    always_comb begin
        dec       = BUBBLE;
        dec.valid = 1'b1;
        dec.rs    = rs;
        dec.rt    = rt;
        dec.dest  = (op == OP_SPECIAL || op == OP_SPECIAL2) ? rd : (op == OP_JAL) ? 5'd31 : rt;
        dec.aluop = A_ADD;
        uses_rt   = 1'b0;
        hilo_op   = 1'b0;
        mul_op    = 1'b0;
        r_alu     = 1'b0;
        i_alu     = 1'b0;
        if (op == OP_SPECIAL) begin
            case (fn)
                6'h00: begin dec.aluop = A_SLL;  r_alu = 1'b1; end
                6'h02: begin dec.aluop = A_SRL;  r_alu = 1'b1; end
                6'h03: begin dec.aluop = A_SRA;  r_alu = 1'b1; end
                6'h04: begin dec.aluop = A_SLLV; r_alu = 1'b1; end
                6'h06: begin dec.aluop = A_SRLV; r_alu = 1'b1; end
                6'h07: begin dec.aluop = A_SRAV; r_alu = 1'b1; end
                6'h08: dec.jr = 1'b1;
                6'h10: begin dec.aluop = A_MFHI; dec.regwrite = 1'b1; hilo_op = 1'b1; end
                6'h11: begin dec.aluop = A_MTHI; hilo_op = 1'b1; end
                6'h12: begin dec.aluop = A_MFLO; dec.regwrite = 1'b1; hilo_op = 1'b1; end
                6'h13: begin dec.aluop = A_MTLO; hilo_op = 1'b1; end
                6'h18: begin dec.aluop = A_MULT;  uses_rt = 1'b1; hilo_op = 1'b1; mul_op = 1'b1; end
                6'h19: begin dec.aluop = A_MULTU; uses_rt = 1'b1; hilo_op = 1'b1; mul_op = 1'b1; end
                6'h20: begin dec.aluop = A_ADD;  r_alu = 1'b1; end
                6'h21: begin dec.aluop = A_ADDU; r_alu = 1'b1; end
                6'h22: begin dec.aluop = A_SUB;  r_alu = 1'b1; end
                6'h23: begin dec.aluop = A_SUBU; r_alu = 1'b1; end
                6'h24: begin dec.aluop = A_AND;  r_alu = 1'b1; end
                6'h25: begin dec.aluop = A_OR;   r_alu = 1'b1; end
                6'h26: begin dec.aluop = A_XOR;  r_alu = 1'b1; end
                6'h27: begin dec.aluop = A_NOR;  r_alu = 1'b1; end
                6'h2A: begin dec.aluop = A_SLT;  r_alu = 1'b1; end
                6'h2B: begin dec.aluop = A_SLTU; r_alu = 1'b1; end
                default: dec.illegal = 1'b1;
            endcase
        end else if (op == OP_SPECIAL2) begin
            case (fn)
                6'h00: begin dec.aluop = A_MADD; uses_rt = 1'b1; hilo_op = 1'b1; mul_op = 1'b1; end
                6'h04: begin dec.aluop = A_MSUB; uses_rt = 1'b1; hilo_op = 1'b1; mul_op = 1'b1; end
                6'h02: begin dec.aluop = A_MUL;  uses_rt = 1'b1; hilo_op = 1'b1; dec.regwrite = 1'b1; end
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            case (op)
                6'h02: dec.jump = 1'b1;
                6'h03: begin dec.jump = 1'b1; dec.jumplink = 1'b1; dec.regwrite = 1'b1; end
                6'h04, 6'h05: begin dec.branch = 1'b1; dec.aluop = A_SUB; uses_rt = 1'b1; end
                6'h08: begin dec.aluop = A_ADD;  i_alu = 1'b1; end
                6'h09: begin dec.aluop = A_ADDU; i_alu = 1'b1; end
                6'h0A: begin dec.aluop = A_SLT;  i_alu = 1'b1; end
                6'h0B: begin dec.aluop = A_SLTU; i_alu = 1'b1; end
                6'h0C: begin dec.aluop = A_AND;  i_alu = 1'b1; end
                6'h0D: begin dec.aluop = A_OR;   i_alu = 1'b1; end
                6'h0E: begin dec.aluop = A_XOR;  i_alu = 1'b1; end
                6'h0F: begin dec.aluop = A_LUI;  i_alu = 1'b1; end
                6'h20, 6'h21, 6'h23: begin
                    dec.regwrite = 1'b1;
                    dec.memread  = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.load     = (op == 6'h23) ? 2'b00 : (op == 6'h21) ? 2'b01 : 2'b10;
                end
                6'h28, 6'h29, 6'h2B: begin
                    dec.memwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    uses_rt      = 1'b1;
                    dec.store    = (op == 6'h2B) ? 2'b00 : (op == 6'h29) ? 2'b01 : 2'b10;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        if (r_alu) begin
            dec.regwrite = 1'b1;
            uses_rt      = 1'b1;
        end
        if (i_alu) begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
        end
    end

    // $0 as a load destination never creates a dependency
    assign load_use = ex_q.valid & ex_q.memread & (ex_q.dest != 5'd0) &
                      ((ex_q.dest == rs) | (uses_rt & (ex_q.dest == rt)));
    assign hilo_use = (busy_q != '0) & hilo_op;
    assign stall    = (id_valid & (load_use | hilo_use)) | ex_hold;
    assign id_ready = ~stall;
    assign accept   = id_valid & ~stall & ~flush & ~ex_hold;

    assign ex_d   = ex_hold ? ex_q : accept ? dec : BUBBLE;
    assign busy_d = (accept & mul_op) ? CNT_W'(MUL_LATENCY) : (busy_q != '0) ? busy_q - 1'b1 : busy_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_q   <= BUBBLE;
            busy_q <= '0;
        end else begin
            ex_q   <= ex_d;
            busy_q <= busy_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_branch   = ex_q.branch;
    assign ex_jump     = ex_q.jump;
    assign ex_jumplink = ex_q.jumplink;
    assign ex_jr       = ex_q.jr;
    assign ex_aluop    = ex_q.aluop;
    assign ex_load     = ex_q.load;
    assign ex_store    = ex_q.store;
    assign ex_dest     = ex_q.dest;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_illegal  = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed scenarios plus randomized traffic checked every cycle
// against an instruction-class reference model of the decode stage.
module tb_decode_stage_pipe;
    localparam int MUL_LAT = 3;

    typedef struct packed {
        logic       valid, regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, jumplink, jr;
        logic [5:0] aluop;
        logic [1:0] load, store;
        logic [4:0] dest, rs, rt;
        logic       illegal;
    } bun_t;

    typedef enum int {C_ILL, C_RALU, C_JR, C_MF, C_MT, C_MACC, C_MUL, C_BR, C_IALU, C_LD, C_ST, C_J, C_JAL} cls_t;

    logic        clk, rst_n;
    logic [31:0] id_instr;
    logic        id_valid, flush, ex_hold, id_ready;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
    logic        ex_branch, ex_jump, ex_jumplink, ex_jr, ex_illegal;
    logic [5:0]  ex_aluop;
    logic [1:0]  ex_load, ex_store;
    logic [4:0]  ex_dest, ex_rs, ex_rt;
    bun_t        got, m_ex;
    int          m_busy;
    int          n_run = 0, n_fail = 0;

    localparam bun_t BUB = bun_t'({10'b0, 6'b0, 4'b1111, 16'b0});

    localparam logic [31:0] LW   = 32'h8E080000;
    localparam logic [31:0] ADD  = 32'h01084820;
    localparam logic [31:0] MULT = 32'h00850018;
    localparam logic [31:0] MFLO = 32'h00005012;
    localparam logic [31:0] SW   = 32'hAE080000;
    localparam logic [31:0] ILL  = 32'hFC000000;
    localparam logic [31:0] LW0  = 32'h8C000000;
    localparam logic [31:0] ADD0 = 32'h00004820;

    decode_stage_pipe #(.ALUOP_W(6), .MUL_LATENCY(MUL_LAT), .CNT_W(4)) dut (
        .Clk(clk), .Rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .id_ready(id_ready),
        .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jumplink(ex_jumplink),
        .ex_jr(ex_jr), .ex_aluop(ex_aluop), .ex_load(ex_load), .ex_store(ex_store),
        .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_illegal(ex_illegal)
    );

    assign got = {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch,
                  ex_jump, ex_jumplink, ex_jr, ex_aluop, ex_load, ex_store, ex_dest, ex_rs, ex_rt, ex_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference decode: classify the instruction, then derive every control field from its class.
    function automatic bun_t model_dec(input logic [31:0] ins, output bit ur, output bit hl, output bit ml);
        logic [5:0] op, fn;
        cls_t c;
        int alu;
        logic [1:0] sz;
        bun_t b;
        op = ins[31:26]; fn = ins[5:0]; c = C_ILL; alu = 0; sz = 2'b00;
        if (op == 6'h00) begin
            case (fn)
                6'h00: begin c = C_RALU; alu = 8; end
                6'h02: begin c = C_RALU; alu = 9; end
                6'h03: begin c = C_RALU; alu = 10; end
                6'h04: begin c = C_RALU; alu = 11; end
                6'h06: begin c = C_RALU; alu = 12; end
                6'h07: begin c = C_RALU; alu = 13; end
                6'h08: c = C_JR;
                6'h10: begin c = C_MF; alu = 19; end
                6'h11: begin c = C_MT; alu = 21; end
                6'h12: begin c = C_MF; alu = 20; end
                6'h13: begin c = C_MT; alu = 22; end
                6'h18: begin c = C_MACC; alu = 17; end
                6'h19: begin c = C_MACC; alu = 18; end
                6'h20: begin c = C_RALU; alu = 0; end
                6'h21: begin c = C_RALU; alu = 15; end
                6'h22: begin c = C_RALU; alu = 1; end
                6'h23: begin c = C_RALU; alu = 16; end
                6'h24: begin c = C_RALU; alu = 2; end
                6'h25: begin c = C_RALU; alu = 3; end
                6'h26: begin c = C_RALU; alu = 4; end
                6'h27: begin c = C_RALU; alu = 5; end
                6'h2A: begin c = C_RALU; alu = 6; end
                6'h2B: begin c = C_RALU; alu = 7; end
                default: c = C_ILL;
            endcase
        end else if (op == 6'h1C) begin
            case (fn)
                6'h00: begin c = C_MACC; alu = 23; end
                6'h04: begin c = C_MACC; alu = 24; end
                6'h02: begin c = C_MUL; alu = 25; end
                default: c = C_ILL;
            endcase
        end else begin
            case (op)
                6'h02: c = C_J;
                6'h03: c = C_JAL;
                6'h04, 6'h05: begin c = C_BR; alu = 1; end
                6'h08: begin c = C_IALU; alu = 0; end
                6'h09: begin c = C_IALU; alu = 15; end
                6'h0A: begin c = C_IALU; alu = 6; end
                6'h0B: begin c = C_IALU; alu = 7; end
                6'h0C: begin c = C_IALU; alu = 2; end
                6'h0D: begin c = C_IALU; alu = 3; end
                6'h0E: begin c = C_IALU; alu = 4; end
                6'h0F: begin c = C_IALU; alu = 14; end
                6'h20: begin c = C_LD; sz = 2'b10; end
                6'h21: begin c = C_LD; sz = 2'b01; end
                6'h23: begin c = C_LD; sz = 2'b00; end
                6'h28: begin c = C_ST; sz = 2'b10; end
                6'h29: begin c = C_ST; sz = 2'b01; end
                6'h2B: begin c = C_ST; sz = 2'b00; end
                default: c = C_ILL;
            endcase
        end
        b = BUB;
        b.valid    = 1'b1;
        b.rs       = ins[25:21];
        b.rt       = ins[20:16];
        b.dest     = (op == 6'h00 || op == 6'h1C) ? ins[15:11] : (op == 6'h03) ? 5'd31 : ins[20:16];
        b.aluop    = 6'(alu);
        b.regwrite = c inside {C_RALU, C_MF, C_MUL, C_IALU, C_LD, C_JAL};
        b.memread  = (c == C_LD);
        b.memtoreg = (c == C_LD);
        b.memwrite = (c == C_ST);
        b.alusrc   = c inside {C_IALU, C_LD, C_ST};
        b.branch   = (c == C_BR);
        b.jump     = c inside {C_J, C_JAL};
        b.jumplink = (c == C_JAL);
        b.jr       = (c == C_JR);
        b.load     = (c == C_LD) ? sz : 2'b11;
        b.store    = (c == C_ST) ? sz : 2'b11;
        b.illegal  = (c == C_ILL);
        ur = c inside {C_RALU, C_MACC, C_MUL, C_BR, C_ST};
        hl = c inside {C_MF, C_MT, C_MACC, C_MUL};
        ml = (c == C_MACC);
        return b;
    endfunction

    function automatic bit model_ready();
        bit ur, hl, ml, lu, hu;
        bun_t d;
        d  = model_dec(id_instr, ur, hl, ml);
        lu = m_ex.valid && m_ex.memread && m_ex.dest != 0 &&
             (m_ex.dest == d.rs || (ur && m_ex.dest == d.rt));
        hu = (m_busy > 0) && hl;
        return !((id_valid && (lu || hu)) || ex_hold);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit ur, hl, ml, rdy, acc;
        bun_t d;
        if (!rst_n) begin
            m_ex   = BUB;
            m_busy = 0;
        end else begin
            rdy = model_ready();
            d   = model_dec(id_instr, ur, hl, ml);
            acc = id_valid && rdy && !flush && !ex_hold;
            if (acc && ml) m_busy = MUL_LAT;
            else if (m_busy > 0) m_busy = m_busy - 1;
            if (!ex_hold) m_ex = acc ? d : BUB;
        end
    end

    always @(negedge clk) begin
        #1;
        chk("id_ready", 64'(id_ready), 64'(model_ready()));
        chk("ex_bundle", 64'(got), 64'(m_ex));
    end

    task automatic drive(input logic [31:0] i, input logic v, input logic f, input logic h);
        @(negedge clk);
        id_instr = i; id_valid = v; flush = f; ex_hold = h;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] bases [36];
        logic [31:0] ins;
        bases = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A, 32'h2B,
                  32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07, 32'h08, 32'h09, 32'h10, 32'h11,
                  32'h12, 32'h13, 32'h18, 32'h19, 32'h70000000, 32'h70000004, 32'h70000002,
                  32'h10000000, 32'h20000000, 32'h3C000000, 32'h80000000, 32'h84000000,
                  32'h8C000000, 32'hA4000000, 32'hAC000000, 32'h0C000000};
        if ($urandom_range(0, 19) == 0) return $urandom;
        ins = bases[$urandom_range(0, 35)];
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        if (ins[31:26] == 6'h00 || ins[31:26] == 6'h1C) begin
            ins[15:11] = 5'($urandom_range(0, 3));
            ins[10:6]  = 5'($urandom_range(0, 31));
        end else begin
            ins[15:0] = 16'($urandom_range(0, 65535));
        end
        return ins;
    endfunction

    initial begin
        int stalls;
        rst_n = 1'b0; id_instr = '0; id_valid = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", 64'(ex_valid), 0);
        chk("rst_load", 64'(ex_load), 3);
        chk("rst_store", 64'(ex_store), 3);
        @(negedge clk);
        rst_n = 1'b1;
        // load-use
        drive(LW, 1, 0, 0);   #2; chk("lu_ready0", 64'(id_ready), 1);
        drive(ADD, 1, 0, 0);  #2; chk("lu_stall", 64'(id_ready), 0); chk("lu_memread", 64'(ex_memread), 1);
        drive(ADD, 1, 0, 0);  #2; chk("lu_bubble", 64'(ex_valid), 0); chk("lu_ready1", 64'(id_ready), 1);
        drive('0, 0, 0, 0);   #2; chk("lu_add_valid", 64'(ex_valid), 1);
        chk("lu_add_dest", 64'(ex_dest), 9); chk("lu_add_aluop", 64'(ex_aluop), 0);
        // HI/LO latency
        drive(MULT, 1, 0, 0); #2; chk("mul_ready", 64'(id_ready), 1);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            drive(MFLO, 1, 0, 0); #2;
            if (id_ready) break;
            stalls++;
        end
        chk("mul_stall_cycles", 64'(stalls), 3);
        drive('0, 0, 0, 0);   #2; chk("mflo_aluop", 64'(ex_aluop), 20); chk("mflo_dest", 64'(ex_dest), 10);
        // flush
        drive(ADD, 1, 1, 0);  #2; chk("fl_ready", 64'(id_ready), 1);
        drive('0, 0, 0, 0);   #2; chk("fl_valid", 64'(ex_valid), 0); chk("fl_regwrite", 64'(ex_regwrite), 0);
        // downstream hold
        drive(SW, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(ADD, 1, 0, 1); #2;
            chk("hold_ready", 64'(id_ready), 0);
            chk("hold_memwrite", 64'(ex_memwrite), 1);
            chk("hold_store", 64'(ex_store), 0);
        end
        drive(ADD, 1, 0, 0);  #2; chk("hold_kept", 64'(ex_memwrite), 1);
        drive('0, 0, 0, 0);   #2; chk("hold_add", 64'(ex_regwrite), 1);
        // async reset mid-multiply
        drive(MULT, 1, 0, 0);
        drive(MFLO, 1, 0, 0);
        drive(MFLO, 1, 0, 0); #2; chk("rm_stall", 64'(id_ready), 0);
        rst_n = 1'b0; #1;
        chk("rm_valid", 64'(ex_valid), 0); chk("rm_ready", 64'(id_ready), 1);
        @(negedge clk); rst_n = 1'b1; #2; chk("rm_ready_rel", 64'(id_ready), 1);
        drive('0, 0, 0, 0);   #2; chk("rm_mflo", 64'(ex_aluop), 20); chk("rm_mflo_v", 64'(ex_valid), 1);
        // illegal and $0 load
        drive(ILL, 1, 0, 0);  #2; chk("ill_ready", 64'(id_ready), 1);
        drive('0, 0, 0, 0);   #2;
        chk("ill_valid", 64'(ex_valid), 1); chk("ill_flag", 64'(ex_illegal), 1);
        chk("ill_regwrite", 64'(ex_regwrite), 0); chk("ill_memwrite", 64'(ex_memwrite), 0);
        drive(LW0, 1, 0, 0);
        drive(ADD0, 1, 0, 0); #2; chk("r0_nostall", 64'(id_ready), 1);
        drive('0, 0, 0, 0);   #2; chk("r0_add_dest", 64'(ex_dest), 9);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(rand_instr(), 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 19) < 3));
            if ($urandom_range(0, 299) == 0) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk); #2;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
